// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// wb_commit_stage : writeback/commit stage driving GPR/CSR writes, exception,
//                   interrupt and ERTN commits, flush/drain and retire count.
// Revision        : 1.0
// ============================================================================
module wb_commit_stage #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int CADDR_W   = 14,
  parameter int ECODE_W   = 6,
  parameter int DRAIN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_valid_i,
  output logic               mem_allowin_o,
  input  logic [31:0]        mem_pc_i,
  input  logic               mem_rf_we_i,
  input  logic [RADDR_W-1:0] mem_rf_waddr_i,
  input  logic [DATA_W-1:0]  mem_rf_wdata_i,
  input  logic               mem_csr_we_i,
  input  logic [CADDR_W-1:0] mem_csr_waddr_i,
  input  logic [DATA_W-1:0]  mem_csr_wmask_i,
  input  logic [DATA_W-1:0]  mem_csr_wdata_i,
  input  logic               mem_excep_i,
  input  logic [ECODE_W-1:0] mem_ecode_i,
  input  logic [31:0]        mem_badv_i,
  input  logic               mem_ertn_i,
  input  logic               interrupt_en_i,
  input  logic               commit_hold_i,
  output logic               rf_we_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]  rf_wdata_o,
  output logic               csr_we_o,
  output logic [CADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0]  csr_wmask_o,
  output logic [DATA_W-1:0]  csr_wdata_o,
  output logic               excep_en_o,
  output logic [ECODE_W-1:0] excep_ecode_o,
  output logic [31:0]        excep_pc_o,
  output logic [31:0]        excep_badv_o,
  output logic               ertn_en_o,
  output logic               flush_o,
  output logic [63:0]        retire_cnt_o
);

  localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYC);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   drain_cnt, drain_nxt;

  logic               wb_valid;
  logic [31:0]        wb_pc;
  logic               wb_rf_we;
  logic [RADDR_W-1:0] wb_rf_waddr;
  logic [DATA_W-1:0]  wb_rf_wdata;
  logic               wb_csr_we;
  logic [CADDR_W-1:0] wb_csr_waddr;
  logic [DATA_W-1:0]  wb_csr_wmask;
  logic [DATA_W-1:0]  wb_csr_wdata;
  logic               wb_excep;
  logic [ECODE_W-1:0] wb_ecode;
  logic [31:0]        wb_badv;
  logic               wb_ertn;
  logic [63:0]        retire_cnt;

  logic commit, take_int, take_exc, take_ertn, take_norm, flush, accept;

  // Commit priority: interrupt > exception > ertn > normal retire.
  assign commit    = wb_valid & ~commit_hold_i & (state == S_RUN);
  assign take_int  = commit & interrupt_en_i;
  assign take_exc  = commit & ~interrupt_en_i & wb_excep;
  assign take_ertn = commit & ~interrupt_en_i & ~wb_excep & wb_ertn;
  assign take_norm = commit & ~interrupt_en_i & ~wb_excep & ~wb_ertn;
  assign flush     = take_int | take_exc | take_ertn;

  // Flush and drain cycles sink MEM offers without latching them.
  assign mem_allowin_o = rst_n & ((state == S_DRAIN) | flush | ~commit_hold_i | ~wb_valid);
  assign accept        = mem_valid_i & mem_allowin_o & (state == S_RUN) & ~flush;

  assign rf_we_o       = take_norm & wb_rf_we & (wb_rf_waddr != '0);
  assign rf_waddr_o    = rf_we_o ? wb_rf_waddr : '0;
  assign rf_wdata_o    = rf_we_o ? wb_rf_wdata : '0;
  assign csr_we_o      = take_norm & wb_csr_we;
  assign csr_waddr_o   = csr_we_o ? wb_csr_waddr : '0;
  assign csr_wmask_o   = csr_we_o ? wb_csr_wmask : '0;
  assign csr_wdata_o   = csr_we_o ? wb_csr_wdata : '0;
  assign excep_en_o    = take_int | take_exc;
  assign excep_ecode_o = take_exc ? wb_ecode : '0;
  assign excep_pc_o    = excep_en_o ? wb_pc : '0;
  assign excep_badv_o  = take_exc ? wb_badv : '0;
  assign ertn_en_o     = take_ertn;
  assign flush_o       = flush;
  assign retire_cnt_o  = retire_cnt;

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (flush) begin
      state_nxt = S_DRAIN;
      drain_nxt = DRAIN_INIT;
    end else if (state == S_DRAIN) begin
      drain_nxt = drain_cnt - CNT_W'(1);
      if (drain_cnt == CNT_W'(1)) state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_pc        <= '0;
      wb_rf_we     <= 1'b0;
      wb_rf_waddr  <= '0;
      wb_rf_wdata  <= '0;
      wb_csr_we    <= 1'b0;
      wb_csr_waddr <= '0;
      wb_csr_wmask <= '0;
      wb_csr_wdata <= '0;
      wb_excep     <= 1'b0;
      wb_ecode     <= '0;
      wb_badv      <= '0;
      wb_ertn      <= 1'b0;
    end else if (accept) begin
      wb_valid     <= 1'b1;
      wb_pc        <= mem_pc_i;
      wb_rf_we     <= mem_rf_we_i;
      wb_rf_waddr  <= mem_rf_waddr_i;
      wb_rf_wdata  <= mem_rf_wdata_i;
      wb_csr_we    <= mem_csr_we_i;
      wb_csr_waddr <= mem_csr_waddr_i;
      wb_csr_wmask <= mem_csr_wmask_i;
      wb_csr_wdata <= mem_csr_wdata_i;
      wb_excep     <= mem_excep_i;
      wb_ecode     <= mem_ecode_i;
      wb_badv      <= mem_badv_i;
      wb_ertn      <= mem_ertn_i;
    end else if (commit) begin
      wb_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (take_norm | take_ertn) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// Scoreboard bench for wb_commit_stage: a transaction-level model predicts
// commit events, which a negedge monitor pops and compares.
module tb_wb_commit_stage;
  localparam int DATA_W = 32, RADDR_W = 5, CADDR_W = 14, ECODE_W = 6, DRAIN_CYC = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid_i = 0, mem_allowin_o;
  logic [31:0] mem_pc_i = 0;
  logic mem_rf_we_i = 0;
  logic [RADDR_W-1:0] mem_rf_waddr_i = 0;
  logic [DATA_W-1:0] mem_rf_wdata_i = 0;
  logic mem_csr_we_i = 0;
  logic [CADDR_W-1:0] mem_csr_waddr_i = 0;
  logic [DATA_W-1:0] mem_csr_wmask_i = 0, mem_csr_wdata_i = 0;
  logic mem_excep_i = 0;
  logic [ECODE_W-1:0] mem_ecode_i = 0;
  logic [31:0] mem_badv_i = 0;
  logic mem_ertn_i = 0, interrupt_en_i = 0, commit_hold_i = 0;
  logic rf_we_o, csr_we_o, excep_en_o, ertn_en_o, flush_o;
  logic [RADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o, csr_wmask_o, csr_wdata_o;
  logic [CADDR_W-1:0] csr_waddr_o;
  logic [ECODE_W-1:0] excep_ecode_o;
  logic [31:0] excep_pc_o, excep_badv_o;
  logic [63:0] retire_cnt_o;

  wb_commit_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CADDR_W(CADDR_W),
                    .ECODE_W(ECODE_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .mem_allowin_o(mem_allowin_o),
    .mem_pc_i(mem_pc_i), .mem_rf_we_i(mem_rf_we_i), .mem_rf_waddr_i(mem_rf_waddr_i),
    .mem_rf_wdata_i(mem_rf_wdata_i), .mem_csr_we_i(mem_csr_we_i),
    .mem_csr_waddr_i(mem_csr_waddr_i), .mem_csr_wmask_i(mem_csr_wmask_i),
    .mem_csr_wdata_i(mem_csr_wdata_i), .mem_excep_i(mem_excep_i), .mem_ecode_i(mem_ecode_i),
    .mem_badv_i(mem_badv_i), .mem_ertn_i(mem_ertn_i), .interrupt_en_i(interrupt_en_i),
    .commit_hold_i(commit_hold_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wmask_o(csr_wmask_o), .csr_wdata_o(csr_wdata_o), .excep_en_o(excep_en_o),
    .excep_ecode_o(excep_ecode_o), .excep_pc_o(excep_pc_o), .excep_badv_o(excep_badv_o),
    .ertn_en_o(ertn_en_o), .flush_o(flush_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic rf_we; logic [RADDR_W-1:0] waddr; logic [DATA_W-1:0] wdata;
    logic csr_we; logic [CADDR_W-1:0] caddr; logic [DATA_W-1:0] cmask; logic [DATA_W-1:0] cdata;
    logic excep; logic [ECODE_W-1:0] ecode; logic [31:0] badv; logic ertn;
  } instr_t;

  typedef struct packed {
    logic rf_we; logic [RADDR_W-1:0] waddr; logic [DATA_W-1:0] wdata;
    logic csr_we; logic [CADDR_W-1:0] caddr; logic [DATA_W-1:0] cmask; logic [DATA_W-1:0] cdata;
    logic excep_en; logic [ECODE_W-1:0] ecode; logic [31:0] pc; logic [31:0] badv;
    logic ertn_en; logic flush; logic [63:0] cnt;
  } evt_t;

  evt_t   expq[$];
  int     checks = 0, failures = 0;
  bit     chk_en = 0;
  logic   exp_allow = 1'b0;

  // Reference model: at most one instruction parked in WB, a drain window
  // length after each flush, and the architectural retire count.
  bit          m_valid = 0;
  instr_t      m_in;
  int          m_drain = 0;
  logic [63:0] m_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_step(input instr_t in, input bit v, input bit intr, input bit hold);
    evt_t e;
    bit flushing, accept;
    e = '0;
    flushing = 0;
    exp_allow = (m_drain > 0) || !hold || !m_valid;
    if (m_valid && !hold) begin
      if (intr) begin
        e.excep_en = 1; e.pc = m_in.pc; e.flush = 1;
      end else if (m_in.excep) begin
        e.excep_en = 1; e.ecode = m_in.ecode; e.pc = m_in.pc; e.badv = m_in.badv; e.flush = 1;
      end else if (m_in.ertn) begin
        e.ertn_en = 1; e.flush = 1;
      end else begin
        if (m_in.rf_we && m_in.waddr != 0) begin
          e.rf_we = 1; e.waddr = m_in.waddr; e.wdata = m_in.wdata;
        end
        if (m_in.csr_we) begin
          e.csr_we = 1; e.caddr = m_in.caddr; e.cmask = m_in.cmask; e.cdata = m_in.cdata;
        end
      end
      e.cnt = m_cnt;
      flushing = e.flush;
      if (flushing) exp_allow = 1'b1;
      if (e.flush || e.rf_we || e.csr_we || e.excep_en || e.ertn_en) expq.push_back(e);
      if (!e.excep_en) m_cnt = m_cnt + 64'd1;
      m_valid = 0;
    end
    accept = v && exp_allow && (m_drain == 0) && !flushing;
    if (flushing) m_drain = DRAIN_CYC;
    else if (m_drain > 0) m_drain--;
    if (accept) begin
      m_in = in;
      m_valid = 1;
    end
    chk_en = 1;
  endtask

  task automatic drive(input instr_t in, input bit v, input bit intr, input bit hold);
    @(posedge clk);
    #1;
    mem_valid_i = v;         mem_pc_i = in.pc;
    mem_rf_we_i = in.rf_we;  mem_rf_waddr_i = in.waddr;  mem_rf_wdata_i = in.wdata;
    mem_csr_we_i = in.csr_we; mem_csr_waddr_i = in.caddr;
    mem_csr_wmask_i = in.cmask; mem_csr_wdata_i = in.cdata;
    mem_excep_i = in.excep;  mem_ecode_i = in.ecode;  mem_badv_i = in.badv;
    mem_ertn_i = in.ertn;    interrupt_en_i = intr;  commit_hold_i = hold;
    model_step(in, v, intr, hold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 0, 0, 0);
  endtask

  function automatic instr_t rnd_instr();
    instr_t r;
    r.pc = $urandom;  r.rf_we = ($urandom_range(0, 9) < 6);
    r.waddr = RADDR_W'($urandom); r.wdata = $urandom;
    r.csr_we = ($urandom_range(0, 9) < 3); r.caddr = CADDR_W'($urandom);
    r.cmask = $urandom; r.cdata = $urandom;
    r.excep = ($urandom_range(0, 9) == 0); r.ecode = ECODE_W'($urandom);
    r.badv = $urandom; r.ertn = ($urandom_range(0, 11) == 0);
    return r;
  endfunction

  function automatic instr_t mk_rf(input logic [4:0] a, input logic [31:0] d);
    instr_t r = '0;
    r.pc = 32'h1C00_0000; r.rf_we = 1; r.waddr = a; r.wdata = d;
    return r;
  endfunction

  function automatic logic [63:0] or_outputs();
    return {32'(rf_we_o | csr_we_o | excep_en_o | ertn_en_o | flush_o | mem_allowin_o),
            32'(rf_waddr_o) | rf_wdata_o | 32'(csr_waddr_o) | csr_wmask_o | csr_wdata_o |
            32'(excep_ecode_o) | excep_pc_o | excep_badv_o} | retire_cnt_o;
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      evt_t a, e;
      bit evt;
      a = {rf_we_o, rf_waddr_o, rf_wdata_o, csr_we_o, csr_waddr_o, csr_wmask_o, csr_wdata_o,
           excep_en_o, excep_ecode_o, excep_pc_o, excep_badv_o, ertn_en_o, flush_o, retire_cnt_o};
      evt = rf_we_o | csr_we_o | excep_en_o | ertn_en_o | flush_o;
      checks++;
      if (mem_allowin_o !== exp_allow) begin
        failures++;
        $display("FAIL allowin @%0t actual=%b required=%b", $time, mem_allowin_o, exp_allow);
      end
      if (evt || expq.size() > 0) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_commit @%0t actual=%h required=none", $time, a);
        end else begin
          e = expq.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL commit_event @%0t actual=%h required=%h", $time, a, e);
          end
        end
      end
    end
  end

  initial begin
    instr_t t;
    #2;
    chk("reset_allowin", 64'(mem_allowin_o), 64'd0);
    chk("reset_outputs", or_outputs(), 64'd0);
    @(posedge clk); #1; rst_n = 1;
    idle(2);
    chk("idle_cnt", retire_cnt_o, 64'd0);

    // single add, then waddr 0
    drive(mk_rf(5'd5, 32'h1234), 1, 0, 0);
    idle(2);
    chk("cnt_after_add", retire_cnt_o, 64'd1);
    drive(mk_rf(5'd0, 32'hBEEF), 1, 0, 0);
    idle(2);
    chk("cnt_after_x0", retire_cnt_o, 64'd2);

    // exception followed by a stream of offers (drain drops)
    t = '0; t.pc = 32'h1C00_0100; t.excep = 1; t.ecode = 6'h0B; t.badv = 32'hDEAD;
    drive(t, 1, 0, 0);
    for (int i = 1; i <= 6; i++) drive(mk_rf(5'(i), 32'(i * 17)), 1, 0, 0);
    idle(2);

    // interrupt beats an exception
    t = '0; t.pc = 32'h1C00_0200; t.excep = 1; t.ecode = 6'h08; t.badv = 32'h55;
    drive(t, 1, 0, 0);
    drive('0, 0, 1, 0);
    idle(4);
    chk("cnt_after_int", retire_cnt_o, m_cnt);

    // CSR write held three cycles
    t = '0; t.csr_we = 1; t.caddr = 14'h0180; t.cmask = 32'hFF00_FF00; t.cdata = 32'hA5A5_5A5A;
    drive(t, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(mk_rf(5'd9, 32'h99), 1, 0, 1);
    drive('0, 0, 0, 0);
    idle(3);

    // retire counter wrap
    idle(1);
    #1;
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(mk_rf(5'd3, 32'h3), 1, 0, 0);
    idle(2);
    chk("cnt_wrap", retire_cnt_o, 64'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      drive(rnd_instr(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) == 0));
    idle(6);
    chk("cnt_random", retire_cnt_o, m_cnt);
    chk("queue_empty", 64'(expq.size()), 64'd0);

    // reset while an instruction is held
    drive(mk_rf(5'd7, 32'h77), 1, 0, 0);
    drive('0, 0, 0, 1);
    @(posedge clk); #1;
    chk_en = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_allowin", 64'(mem_allowin_o), 64'd0);
    chk("rst_mid_outputs", or_outputs(), 64'd0);
    commit_hold_i = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_valid = 0; m_drain = 0; m_cnt = '0;
    expq.delete();
    idle(4);
    chk("rst_lost_instr_cnt", retire_cnt_o, 64'd0);
    drive(mk_rf(5'd4, 32'h44), 1, 0, 0);
    idle(2);
    chk("post_reset_cnt", retire_cnt_o, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
